// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the fetch path: next-PC select codes (also driven by the
// branch control stage) and the fetch FSM state enum.
package pc_fetch_unit_pkg;

   localparam logic [1:0] BR_ALU_OUT = 2'b00;
   localparam logic [1:0] BR_PC_IMM  = 2'b01;
   localparam logic [1:0] BR_PC_4    = 2'b10;

   typedef enum logic [2:0] {
      ST_BOOT = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_HOLD = 3'd3,
      ST_HALT = 3'd4
   } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Combinational next-PC mux plus alignment check of the selected target.
module next_pc_sel
   import pc_fetch_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      branch_ctrl,
   input  logic [XLEN-1:0] alu_out,
   input  logic [XLEN-1:0] pc_imm,
   input  logic [XLEN-1:0] pc_plus4,
   output logic [XLEN-1:0] next_pc,
   output logic            misaligned
);

   // JALR target drops bit 0, so that bit of alu_out is intentionally unused.
   logic unused_alu_bit0;
   assign unused_alu_bit0 = alu_out[0];

   always_comb begin
      next_pc = pc_plus4;
      case (branch_ctrl)
         BR_ALU_OUT: next_pc = {alu_out[XLEN-1:1], 1'b0};
         BR_PC_IMM:  next_pc = pc_imm;
         default:    next_pc = pc_plus4;
      endcase
   end

   assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: one outstanding fetch at a time, holds the fetched
// instruction until retired, then steers the PC; halts on a misaligned target.
//
// Handshakes: imem_req/imem_gnt is valid/ready (request and address held stable
// until gnt); imem_rvalid is only honoured in WAIT; inst_valid/inst_ready is
// valid/ready with inst stable while valid and ready low.
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      branch_ctrl,
   input  logic [XLEN-1:0] alu_out,
   input  logic [XLEN-1:0] pc_imm,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] inst,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic            misalign_err,
   output logic [2:0]      fsm_state
);

   fetch_state_t    state;
   fetch_state_t    state_next;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] inst_q;
   logic            err_q;
   logic [XLEN-1:0] next_pc;
   logic            next_misaligned;
   logic            retire;

   assign pc_plus4  = pc_q + XLEN'(4);
   assign pc        = pc_q;
   assign imem_addr = pc_q;
   assign inst      = inst_q;
   assign misalign_err = err_q;
   assign fsm_state = state;
   assign retire    = (state == ST_HOLD) && inst_ready;

   next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
      .branch_ctrl (branch_ctrl),
      .alu_out     (alu_out),
      .pc_imm      (pc_imm),
      .pc_plus4    (pc_plus4),
      .next_pc     (next_pc),
      .misaligned  (next_misaligned)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_BOOT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_BOOT: state_next = ST_REQ;
         ST_REQ:  if (imem_gnt)    state_next = ST_WAIT;
         ST_WAIT: if (imem_rvalid) state_next = ST_HOLD;
         ST_HOLD: if (inst_ready)  state_next = next_misaligned ? ST_HALT : ST_REQ;
         ST_HALT: state_next = ST_HALT;
         default: state_next = ST_BOOT;
      endcase
   end

   always_comb begin
      imem_req   = 1'b0;
      inst_valid = 1'b0;
      case (state)
         ST_REQ:  imem_req   = 1'b1;
         ST_HOLD: inst_valid = 1'b1;
         default: ;
      endcase
   end

   // A misaligned target leaves pc pointing at the instruction that produced it.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         inst_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if ((state == ST_WAIT) && imem_rvalid) begin
            inst_q <= imem_rdata;
         end
         if (retire) begin
            if (next_misaligned) begin
               err_q <= 1'b1;
            end else begin
               pc_q <= next_pc;
            end
         end
      end
   end

endmodule
